// File: rtl/instr_fetch_unit.sv
// Fetch front end: writable instruction memory, program counter and run/halt sequencer.
// Drives one registered instruction (or a NOP bubble) per clock into the datapath core.
module instr_fetch_unit #(
   parameter int              IW        = 19,
   parameter int              AW        = 6,
   parameter logic [3:0]      HALT_OP   = 4'hF,
   parameter logic [IW-1:0]   NOP_WORD  = '0,
   parameter int              DRAIN_CYC = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic          stall,
   output logic [IW-1:0] instruccion,
   output logic [AW-1:0] pc,
   output logic          running,
   output logic          done
);

   localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_pc, w_pc_nxt;
   logic [IW-1:0] r_instr, w_instr_nxt;
   logic [CW-1:0] r_drain_cnt, w_drain_cnt_nxt;
   logic [IW-1:0] r_imem [2**AW];

   logic [IW-1:0] w_fetch;
   logic          w_is_halt;
   logic          w_pc_last;
   logic          w_load_ok;

   assign w_fetch   = r_imem[r_pc];
   assign w_is_halt = (w_fetch[IW-1 -: 4] == HALT_OP);
   assign w_pc_last = (r_pc == {AW{1'b1}});
   assign w_load_ok = (r_state == S_IDLE) || (r_state == S_DONE);

   // imem survives reset; loads are locked out while a program is in flight
   always_ff @(posedge clk) begin
      if (load_we && w_load_ok)
         r_imem[load_addr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_instr     <= NOP_WORD;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_instr     <= w_instr_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = NOP_WORD;
      w_drain_cnt_nxt = r_drain_cnt;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = '0;
            end
         end
         S_RUN: begin
            // stall takes priority, so a HALT under stall is only seen once stall drops
            if (!stall) begin
               if (w_is_halt) begin
                  w_state_nxt     = S_DRAIN;
                  w_drain_cnt_nxt = CW'(DRAIN_CYC - 1);
               end else begin
                  w_instr_nxt = w_fetch;
                  w_pc_nxt    = r_pc + AW'(1);
                  if (w_pc_last) begin
                     w_state_nxt     = S_DRAIN;
                     w_drain_cnt_nxt = CW'(DRAIN_CYC - 1);
                  end
               end
            end
         end
         S_DRAIN: begin
            if (r_drain_cnt == '0)
               w_state_nxt = S_DONE;
            else
               w_drain_cnt_nxt = r_drain_cnt - CW'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign instruccion = r_instr;
   assign pc          = r_pc;
   assign running     = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: program-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_we = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [18:0] load_data = '0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic [18:0] instruccion;
   logic [5:0]  pc;
   logic        running;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .start(start), .stall(stall),
      .instruccion(instruccion), .pc(pc), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a program either executing, draining a fixed number of
   // bubbles, or parked (idle/done). Expressed with plain integers.
   logic [18:0] m_mem [64];
   bit          m_exec  = 1'b0;
   int          m_drain = -1;   // bubbles still owed before done; -1 when not draining
   bit          m_done  = 1'b0;
   int          m_pc    = 0;
   logic [18:0] m_instr = '0;

   always @(posedge clk) begin
      logic [18:0] w;
      bit          parked;
      parked = !m_exec && (m_drain < 0);
      if (parked && load_we) m_mem[load_addr] = load_data;
      if (!rst_n) begin
         m_exec = 0; m_drain = -1; m_done = 0; m_pc = 0; m_instr = '0;
      end else if (m_exec) begin
         m_instr = '0;
         if (!stall) begin
            w = m_mem[m_pc];
            if (w[18:15] == 4'hF) begin
               m_exec = 0; m_drain = 2;
            end else begin
               m_instr = w;
               if (m_pc == 63) begin
                  m_pc = 0; m_exec = 0; m_drain = 2;
               end else begin
                  m_pc = m_pc + 1;
               end
            end
         end
      end else if (m_drain >= 0) begin
         m_instr = '0;
         if (m_drain == 0) begin m_drain = -1; m_done = 1; end
         else m_drain = m_drain - 1;
      end else begin
         m_instr = '0;
         if (start) begin m_exec = 1; m_pc = 0; m_done = 0; end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_instr",   32'(instruccion), 32'(m_instr));
         check("model_pc",      32'(pc),          32'(m_pc));
         check("model_running", 32'(running),     32'(m_exec || (m_drain >= 0)));
         check("model_done",    32'(done),        32'(m_done));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic load(input logic [5:0] a, input logic [18:0] d);
      load_we = 1'b1; load_addr = a; load_data = d;
      cyc();
      load_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i;
      for (i = 0; i < budget && !done; i++) cyc();
      check(name, 32'(done), 32'd1);
   endtask

   task automatic count_fetches(input logic [18:0] word, output int cnt);
      int i;
      cnt = 0;
      for (i = 0; i < 300 && !done; i++) begin
         cyc();
         if (instruccion == word) cnt++;
      end
      check("fetch_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      int cnt;
      // Reset
      cyc(); cyc();
      chk_en = 1'b1;
      check("rst_instr", 32'(instruccion), 32'h0);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      rst_n = 1'b1;

      // Basic program with HALT
      load(6'd0, 19'h08421); load(6'd1, 19'h0C862); load(6'd2, 19'h78000);
      pulse_start();
      check("p1_start_bubble", 32'(instruccion), 32'h0);
      cyc(); check("p1_w0", 32'(instruccion), 32'h08421); check("p1_pc1", 32'(pc), 32'd1);
      cyc(); check("p1_w1", 32'(instruccion), 32'h0C862);
      cyc(); check("p1_halt_nop", 32'(instruccion), 32'h0); check("p1_halt_pc", 32'(pc), 32'd2);
      check("p1_drain_run", 32'(running), 32'd1);
      cyc(); check("p1_done_h1", 32'(done), 32'd0);
      cyc(); check("p1_done_h2", 32'(done), 32'd0);
      cyc(); check("p1_done_h3", 32'(done), 32'd1); check("p1_run_off", 32'(running), 32'd0);

      // Stall after the first fetch
      pulse_start();
      cyc(); check("p2_w0", 32'(instruccion), 32'h08421);
      stall = 1'b1;
      cyc(); check("p2_stall0", 32'(instruccion), 32'h0); check("p2_pc_s0", 32'(pc), 32'd1);
      cyc(); check("p2_stall1", 32'(instruccion), 32'h0); check("p2_pc_s1", 32'(pc), 32'd1);
      stall = 1'b0;
      cyc(); check("p2_w1", 32'(instruccion), 32'h0C862);
      wait_done("p2_done", 10);

      // Full memory, no HALT: implicit halt at wrap
      for (int a = 0; a < 64; a++) load(6'(a), 19'h04000);
      pulse_start();
      count_fetches(19'h04000, cnt);
      check("p3_fetches", 32'(cnt), 32'd64);
      check("p3_pc_wrap", 32'(pc), 32'd0);

      // Loads during RUN are ignored; reset mid-RUN
      pulse_start();
      load_we = 1'b1; load_addr = 6'd3; load_data = 19'h78000;
      cyc(); cyc();
      load_we = 1'b0;
      for (int i = 0; i < 20 && pc != 6'd5; i++) cyc();
      check("p4_reach_pc5", 32'(pc), 32'd5);
      rst_n = 1'b0;
      cyc();
      check("p4_rst_instr", 32'(instruccion), 32'h0);
      check("p4_rst_pc", 32'(pc), 32'h0);
      check("p4_rst_running", 32'(running), 32'h0);
      rst_n = 1'b1;
      pulse_start();
      count_fetches(19'h04000, cnt);
      check("p4_mem_intact", 32'(cnt), 32'd64);

      // Load a HALT at address 0 together with start while in DONE
      load_we = 1'b1; load_addr = 6'd0; load_data = 19'h78000; start = 1'b1;
      cyc();
      load_we = 1'b0; start = 1'b0;
      check("p5_run", 32'(running), 32'd1); check("p5_done_clr", 32'(done), 32'd0);
      cyc(); check("p5_halt_nop", 32'(instruccion), 32'h0); check("p5_pc0", 32'(pc), 32'd0);
      cyc(); check("p5_d1", 32'(done), 32'd0);
      cyc(); check("p5_d2", 32'(done), 32'd0);
      cyc(); check("p5_d3", 32'(done), 32'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         load_we   = rst_n && ($urandom_range(0, 3) == 0);
         load_addr = 6'($urandom_range(0, 63));
         load_data = 19'($urandom);
         start     = ($urandom_range(0, 7) == 0);
         stall     = ($urandom_range(0, 3) == 0);
         cyc();
      end
      rst_n = 1'b1; load_we = 1'b0; start = 1'b0; stall = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
